// File: rtl/phy_tx_sched_pkg.sv
// phy_pkg: shared widths and scheduler state encodings for the phy transmit path
package phy_pkg;
  localparam int NUM_SRC = 4;
  localparam int WORD_W = 32;
  typedef enum logic {ST_INIT, ST_ACTIVE} state_t;
endpackage

// File: rtl/phy_tx_sched_if.sv
// phy_tx_sched_if: source request bundle and phy transmit port of the scheduler
interface phy_tx_sched_if;
  import phy_pkg::*;
  logic                      tx_enable;
  logic [NUM_SRC-1:0]        req_valid;
  logic [NUM_SRC*WORD_W-1:0] req_data;
  logic [NUM_SRC-1:0]        req_pop;
  logic [WORD_W-1:0]         data_in_tx;
  logic                      valid_in_tx;
  logic [1:0]                grant_id;
  logic                      active;
  modport master (
    output tx_enable, req_valid, req_data,
    input  req_pop, data_in_tx, valid_in_tx, grant_id, active
  );
  modport slave (
    input  tx_enable, req_valid, req_data,
    output req_pop, data_in_tx, valid_in_tx, grant_id, active
  );
endinterface

// File: rtl/phy_tx_sched_rr_next.sv
// rr_next: first valid index after g, searching g+1..g+3 and finally g itself
module rr_next
  import phy_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_valid,
  input  logic [1:0]         g,
  output logic [1:0]         nxt,
  output logic               any
);
  always_comb begin
    nxt = g;
    any = |req_valid;
    for (int k = NUM_SRC; k >= 1; k--)
      if (req_valid[g + 2'(k)]) nxt = g + 2'(k);
  end
endmodule

// File: rtl/phy_tx_sched.sv
// phy_tx_sched: round-robin, burst-limited sharing of the phy transmit port
// between four word sources, with a post-reset idle window.
module phy_tx_sched
  import phy_pkg::*;
#(
  parameter int INIT_CYCLES = 16,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic reset,
  phy_tx_sched_if.slave bus
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  state_t state;
  logic [IW-1:0] init_cnt;
  logic [BW-1:0] burst_cnt;
  logic [1:0] g, nxt;
  logic any, pop, reeval, active;
  logic [WORD_W-1:0] data;
  logic valid;
  rr_next u_rr (.req_valid(bus.req_valid), .g(g), .nxt(nxt), .any(any));
  // a frozen link (tx_enable low) never moves the grant
  always_comb begin
    pop = state == ST_ACTIVE && bus.req_valid[g] && bus.tx_enable;
    reeval = state == ST_ACTIVE &&
             ((pop && burst_cnt == BW'(MAX_BURST - 1)) || (!bus.req_valid[g] && bus.tx_enable));
  end
  assign bus.req_pop = pop ? NUM_SRC'(1) << g : '0;
  assign bus.data_in_tx = data;
  assign bus.valid_in_tx = valid;
  assign bus.grant_id = g;
  assign bus.active = active;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      init_cnt <= '0;
      burst_cnt <= '0;
      g <= '0;
      active <= 1'b0;
      data <= '0;
      valid <= 1'b0;
    end else begin
      valid <= pop;
      data <= pop ? bus.req_data[{g, 5'd0} +: WORD_W] : '0;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == IW'(INIT_CYCLES - 1)) begin
          state <= ST_ACTIVE;
          active <= 1'b1;
        end
      end
      if (reeval) begin
        burst_cnt <= '0;
        if (any) g <= nxt;
      end else if (pop) burst_cnt <= burst_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_phy_tx_sched.sv
// tb_phy_tx_sched: directed and random stimulus against a cycle-level scheduling model
module tb_phy_tx_sched;
  localparam int INIT = 16;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  phy_tx_sched_if bus();
  phy_tx_sched #(.INIT_CYCLES(INIT), .MAX_BURST(MB)) dut (.clk(clk), .reset(reset), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [31:0] word[4];
  bit inc;
  int mg, mcnt, cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic en);
    bit act, p;
    logic [31:0] w;
    bus.req_valid = v;
    bus.tx_enable = en;
    bus.req_data = {word[3], word[2], word[1], word[0]};
    #1;
    act = cyc >= INIT;
    p = act && en && v[mg];
    w = word[mg];
    chk("pop", 32'(bus.req_pop), p ? 32'(1) << mg : 32'd0);
    chk("grant", 32'(bus.grant_id), 32'(mg));
    chk("active", 32'(bus.active), 32'(act));
    @(posedge clk);
    #1;
    chk("valid", 32'(bus.valid_in_tx), 32'(p));
    chk("data", bus.data_in_tx, p ? w : 32'd0);
    if (p) begin
      mcnt++;
      if (inc) word[mg] = word[mg] + 1;
    end
    if (act && ((p && mcnt == MB) || (!v[mg] && en))) begin
      mcnt = 0;
      for (int k = 1; k <= 4; k++)
        if (v[(mg + k) % 4]) begin
          mg = (mg + k) % 4;
          break;
        end
    end
    if (cyc < INIT) cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_data", bus.data_in_tx, 32'd0);
    chk("rst_valid", 32'(bus.valid_in_tx), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    chk("rst_pop", 32'(bus.req_pop), 32'd0);
    mg = 0;
    mcnt = 0;
    cyc = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    inc = 1'b0;
    for (int i = 0; i < 4; i++) word[i] = 32'hA000_0000 + i;
    bus.req_valid = '0;
    bus.tx_enable = 1'b0;
    bus.req_data = '0;
    do_reset();
    for (int n = 0; n < INIT; n++) step(4'hF, 1'b1);
    for (int n = 0; n < 32; n++) begin
      step(4'hF, 1'b1);
      chk("rr_seq", bus.data_in_tx, 32'hA000_0000 + (n / 4) % 4);
    end
    for (int n = 0; n < 12; n++) begin
      step(4'h4, 1'b1);
      if (n >= 1) chk("s2_stream", 32'(bus.valid_in_tx), 32'd1);
    end
    chk("s2_grant", 32'(bus.grant_id), 32'd2);
    do_reset();
    for (int n = 0; n < INIT; n++) step(4'h9, 1'b1);
    step(4'h9, 1'b1);
    step(4'h9, 1'b1);
    chk("s0_word", bus.data_in_tx, 32'hA000_0000);
    step(4'h8, 1'b1);
    chk("bubble", 32'(bus.valid_in_tx), 32'd0);
    for (int n = 0; n < 4; n++) begin
      step(4'h8, 1'b1);
      chk("s3_word", bus.data_in_tx, 32'hA000_0003);
    end
    step(4'hA, 1'b1);
    step(4'hA, 1'b1);
    for (int n = 0; n < 3; n++) begin
      step(4'hA, 1'b0);
      chk("en_low", 32'(bus.valid_in_tx), 32'd0);
    end
    for (int n = 0; n < 2; n++) begin
      step(4'hA, 1'b1);
      chk("resume", bus.data_in_tx, 32'hA000_0003);
    end
    step(4'hA, 1'b1);
    chk("rotate", bus.data_in_tx, 32'hA000_0001);
    inc = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      step(4'($urandom_range(0, 15)), $urandom_range(0, 9) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/phy_tx_sched.md
# phy_tx_sched

Transmit scheduler in front of the `phy` block. It shares the phy's single 32-bit transmit port (`data_in_tx` / `valid_in_tx`) between four word sources using round-robin arbitration with a burst limit. After reset it holds the link idle for a fixed initialization window. It runs entirely in the `clk` domain; the phy's internal `clk_2f` / `clk_4f` / `clk_32f` domains are not touched.

## Interface
- `INIT_CYCLES`, 16: idle cycles after reset before arbitration starts; must be ≥1.
- `MAX_BURST`, 4: maximum words granted to one source before rotation; must be ≥1.
- `clk`  in  1  system clock, the same `clk` that feeds `phy`.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_enable`  in  1  when low, no pops occur and the grant is frozen.
- `req_valid`  in  4  bit i high means source i has a word at its head.
- `req_data`  in  128  source i word on bits [32i+31:32i].
- `req_pop`  out  4  one-hot (or zero); source i word is consumed this cycle.
- `data_in_tx`  out  32  registered word to the phy.
- `valid_in_tx`  out  1  registered valid to the phy.
- `grant_id`  out  2  current grant-holder index.
- `active`  out  1  high in the ACTIVE state.

## Operation
- States and transitions:
  - INIT to ACTIVE when the init counter reaches `INIT_CYCLES`-1.
  - ACTIVE is never left except by reset.
- INIT behaviour:
  - Counter increments every cycle.
  - `req_pop` = 0, `valid_in_tx` = 0, `active` = 0.
- ACTIVE pop rule: `req_pop[g]` = `req_valid[g]` & `tx_enable`, where g = `grant_id`. The rule is combinational; all other pop bits are 0.
- Burst counter:
  - Increments on each pop.
  - Clears whenever the grant is re-evaluated.
- Grant is re-evaluated at the clock edge when either:
  - the pop of the `MAX_BURST`-th word of the current burst occurs, or
  - `req_valid[g]` = 0 and `tx_enable` = 1.
- New grant: the first index with `req_valid` = 1 searching g+1, g+2, g+3, g (mod 4).
  - If no source is valid, g is kept.
  - If only g is valid at burst end, g is re-granted with a fresh burst and no bubble.
- `tx_enable` low:
  - No pops occur.
  - Burst counter and grant hold.
  - `valid_in_tx` goes 0 on the next edge.
- Output register, at every edge:
  - `valid_in_tx` takes `|req_pop`.
  - `data_in_tx` takes the popped source's word, or 32'h0 when nothing is popped.
- Reset mid-operation:
  - All state clears immediately, asynchronously.
  - In-flight registered output is discarded; the word already popped is lost, and the sources own recovery.
  - INIT restarts in full.

## Timing
- Reset values:
  - `req_pop` = 0, `data_in_tx` = 0, `valid_in_tx` = 0, `grant_id` = 0, `active` = 0.
  - State = INIT, both counters = 0.
- `active` rises at the edge that ends cycle `INIT_CYCLES` after reset release. The first pop is possible in that same cycle.
- Latency: a word popped in cycle t appears on `data_in_tx` with `valid_in_tx` = 1 in cycle t+1.
- Throughput:
  - 1 word/cycle while the grant holder stays valid, including across burst-end rotation to a valid source.
  - A grant move caused by the holder going invalid costs exactly one bubble cycle.
- `req_pop` depends combinationally on `req_valid` and `tx_enable`. Sources must not feed `req_pop` back into `req_valid` combinationally.

## Structure
- Shared package `phy_pkg` holds:
  - `NUM_SRC` = 4
  - word width 32
  - state encodings `ST_INIT`, `ST_ACTIVE`
- One natural sub-module is `rr_next`, a combinational round-robin "next valid index" finder: inputs `req_valid` and current g, outputs next index and an any-valid flag.
- Counters, the FSM and the output register stay in the top module.
- The top of the hierarchy instantiates `phy_tx_sched` driving `phy`.

## Test plan
- Reset release with all `req_valid` = 4'hF:
  - `active` = 0 and `req_pop` = 0 for exactly 16 cycles.
  - The first pop is source 0 in cycle 16.
  - `valid_in_tx` = 1 in cycle 17.
- All four sources always valid, with source i supplying 32'hA000_0000+i:
  - Output sequence is 4×A0000000, 4×A0000001, 4×A0000002, 4×A0000003, then repeats.
  - No bubbles.
- Only source 2 valid, continuously:
  - Back-to-back words indefinitely, `grant_id` = 2.
  - Burst rollover creates no bubble.
- Source 0 valid for 2 words then drops, source 3 valid:
  - 2 words from source 0, then one bubble (`valid_in_tx` = 0).
  - Then source 3's words follow.
- `tx_enable` dropped mid-burst after 2 words for 3 cycles:
  - 3 cycles with `valid_in_tx` = 0.
  - Then exactly 2 more words from the same source before rotation.
- `reset` pulsed mid-burst:
  - Outputs go to 0 asynchronously, before the next edge.
  - INIT repeats for 16 cycles.
  - `grant_id` restarts at 0.
